// File: rtl/overflow_event_timer.sv
// rtl/overflow_event_timer.sv - one-shot timeout timer driven by upstream overflow ticks
// Optional auto-reload mode is enabled with `define TIMER_AUTO_RELOAD_EN.
module overflow_event_timer #(
  parameter int TMR_W  = 8,
  parameter int MISS_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              tick_i,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic              ack_i,
`ifdef TIMER_AUTO_RELOAD_EN
  input  logic              auto_reload_i,
`endif
  input  logic [TMR_W-1:0]  period_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              expire_o,
  output logic              err_o,
  output logic [TMR_W-1:0]  remaining_o,
  output logic [MISS_W-1:0] miss_cnt_o
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [TMR_W-1:0]    rem_q, rem_d;
  logic [MISS_W-1:0]   miss_q, miss_d;
  logic                expire_q, expire_d;
  logic                err_q, err_d;
  logic                load;

`ifdef TIMER_AUTO_RELOAD_EN
  logic [TMR_W-1:0]    per_q;
  logic                auto_q;
`endif

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    miss_d   = miss_q;
    expire_d = 1'b0;
    err_d    = 1'b0;
    load     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (period_i != '0) begin
            state_d = S_RUN;
            rem_d   = period_i;
            miss_d  = '0;
            load    = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (stop_i) begin
          state_d = S_IDLE;
          rem_d   = '0;
        end else if (start_i) begin
          // A restart swallows any tick arriving in the same cycle.
          if (period_i != '0) begin
            rem_d = period_i;
            load  = 1'b1;
          end else begin
            state_d = S_IDLE;
            rem_d   = '0;
            err_d   = 1'b1;
          end
        end else if (tick_i) begin
          if (rem_q != TMR_W'(1)) begin
            rem_d = rem_q - TMR_W'(1);
          end else begin
            expire_d = 1'b1;
`ifdef TIMER_AUTO_RELOAD_EN
            if (auto_q) begin
              rem_d = per_q;
            end else begin
              rem_d   = '0;
              state_d = S_DONE;
            end
`else
            rem_d   = '0;
            state_d = S_DONE;
`endif
          end
        end
      end
      S_DONE: begin
        if (start_i && (period_i != '0)) begin
          state_d = S_RUN;
          rem_d   = period_i;
          miss_d  = '0;
          load    = 1'b1;
        end else begin
          // A rejected start still lets ack/stop/tick take effect this cycle.
          err_d = start_i;
          if (tick_i && (miss_q != '1)) begin
            miss_d = miss_q + MISS_W'(1);
          end
          if (ack_i || stop_i) begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      rem_q    <= '0;
      miss_q   <= '0;
      expire_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      miss_q   <= miss_d;
      expire_q <= expire_d;
      err_q    <= err_d;
    end
  end

`ifdef TIMER_AUTO_RELOAD_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      per_q  <= '0;
      auto_q <= 1'b0;
    end else if (load) begin
      per_q  <= period_i;
      auto_q <= auto_reload_i;
    end
  end
`else
  logic unused_load;
  assign unused_load = load;
`endif

  assign busy_o      = (state_q == S_RUN);
  assign done_o      = (state_q == S_DONE);
  assign expire_o    = expire_q;
  assign err_o       = err_q;
  assign remaining_o = rem_q;
  assign miss_cnt_o  = miss_q;

endmodule

// File: tb/tb_overflow_event_timer.sv
// tb/tb_overflow_event_timer.sv - directed vector bench for overflow_event_timer
module tb_overflow_event_timer;

  logic       clk = 1'b0;
  logic       rst, tick, start, stop, ack, auto_reload;
  logic [7:0] period;
  logic       busy, done, expire, err;
  logic [7:0] remaining;
  logic [3:0] miss_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  overflow_event_timer #(.TMR_W(8), .MISS_W(4)) dut (
    .clk_i(clk), .rst_i(rst), .tick_i(tick), .start_i(start), .stop_i(stop), .ack_i(ack),
`ifdef TIMER_AUTO_RELOAD_EN
    .auto_reload_i(auto_reload),
`endif
    .period_i(period), .busy_o(busy), .done_o(done), .expire_o(expire), .err_o(err),
    .remaining_o(remaining), .miss_cnt_o(miss_cnt)
  );

  typedef struct {
    logic       st, sp, ak, tk;
    logic [7:0] per;
    logic [15:0] exp;   // {busy, done, expire, err, remaining[7:0], miss_cnt[3:0]}
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(logic st, logic sp, logic ak, logic tk, logic [7:0] per,
                             logic b, logic d, logic e, logic r, logic [7:0] rem, logic [3:0] m);
    vec_t x;
    x.st = st; x.sp = sp; x.ak = ak; x.tk = tk; x.per = per;
    x.exp = {b, d, e, r, rem, m};
    return x;
  endfunction

  function automatic logic [15:0] outs();
    return {busy, done, expire, err, remaining, miss_cnt};
  endfunction

  task automatic check(string name, logic [15:0] act, logic [15:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h (b d e r rem miss) expected %h", name, act, expv);
    end
  endtask

  task automatic step(logic st, logic sp, logic ak, logic tk, logic [7:0] per);
    start = st; stop = sp; ack = ak; tick = tk; period = per;
    @(posedge clk);
    #1;
    start = 1'b0; stop = 1'b0; ack = 1'b0; tick = 1'b0;
  endtask

  initial begin
    rst = 1'b1; tick = 0; start = 0; stop = 0; ack = 0; auto_reload = 0; period = 0;

    //       st sp ak tk per     b  d  e  r  rem  miss
    vecs.push_back(v(0, 0, 0, 0, 8'd0,  0, 0, 0, 0, 8'd0, 4'd0));
    vecs.push_back(v(1, 0, 0, 0, 8'd0,  0, 0, 0, 1, 8'd0, 4'd0));
    vecs.push_back(v(0, 0, 0, 0, 8'd0,  0, 0, 0, 0, 8'd0, 4'd0));
    vecs.push_back(v(1, 0, 0, 0, 8'd5,  1, 0, 0, 0, 8'd5, 4'd0));
    vecs.push_back(v(0, 0, 0, 1, 8'd0,  1, 0, 0, 0, 8'd4, 4'd0));
    vecs.push_back(v(0, 0, 0, 0, 8'd0,  1, 0, 0, 0, 8'd4, 4'd0));
    vecs.push_back(v(0, 0, 0, 1, 8'd0,  1, 0, 0, 0, 8'd3, 4'd0));
    vecs.push_back(v(0, 0, 0, 1, 8'd0,  1, 0, 0, 0, 8'd2, 4'd0));
    vecs.push_back(v(0, 0, 0, 1, 8'd0,  1, 0, 0, 0, 8'd1, 4'd0));
    vecs.push_back(v(0, 0, 1, 0, 8'd0,  1, 0, 0, 0, 8'd1, 4'd0));
    vecs.push_back(v(0, 0, 0, 1, 8'd0,  0, 1, 1, 0, 8'd0, 4'd0));
    vecs.push_back(v(0, 0, 0, 0, 8'd0,  0, 1, 0, 0, 8'd0, 4'd0));
    vecs.push_back(v(0, 0, 0, 1, 8'd0,  0, 1, 0, 0, 8'd0, 4'd1));
    vecs.push_back(v(0, 0, 1, 1, 8'd0,  0, 0, 0, 0, 8'd0, 4'd2));
    vecs.push_back(v(0, 0, 0, 1, 8'd0,  0, 0, 0, 0, 8'd0, 4'd2));
    vecs.push_back(v(0, 1, 0, 0, 8'd0,  0, 0, 0, 0, 8'd0, 4'd2));
    vecs.push_back(v(1, 0, 0, 0, 8'd3,  1, 0, 0, 0, 8'd3, 4'd0));
    vecs.push_back(v(0, 1, 0, 0, 8'd0,  0, 0, 0, 0, 8'd0, 4'd0));
    vecs.push_back(v(1, 0, 0, 0, 8'd4,  1, 0, 0, 0, 8'd4, 4'd0));
    vecs.push_back(v(0, 0, 0, 1, 8'd0,  1, 0, 0, 0, 8'd3, 4'd0));
    vecs.push_back(v(1, 0, 0, 1, 8'd2,  1, 0, 0, 0, 8'd2, 4'd0));
    vecs.push_back(v(0, 0, 0, 1, 8'd0,  1, 0, 0, 0, 8'd1, 4'd0));
    vecs.push_back(v(0, 1, 0, 1, 8'd0,  0, 0, 0, 0, 8'd0, 4'd0));
    vecs.push_back(v(0, 0, 0, 0, 8'd0,  0, 0, 0, 0, 8'd0, 4'd0));
    vecs.push_back(v(1, 0, 0, 0, 8'd1,  1, 0, 0, 0, 8'd1, 4'd0));
    vecs.push_back(v(0, 0, 0, 1, 8'd0,  0, 1, 1, 0, 8'd0, 4'd0));
    vecs.push_back(v(1, 0, 0, 0, 8'd2,  1, 0, 0, 0, 8'd2, 4'd0));
    vecs.push_back(v(1, 0, 0, 0, 8'd0,  0, 0, 0, 1, 8'd0, 4'd0));
    vecs.push_back(v(1, 0, 0, 0, 8'd2,  1, 0, 0, 0, 8'd2, 4'd0));
    vecs.push_back(v(0, 0, 0, 1, 8'd0,  1, 0, 0, 0, 8'd1, 4'd0));
    vecs.push_back(v(0, 0, 0, 1, 8'd0,  0, 1, 1, 0, 8'd0, 4'd0));
    vecs.push_back(v(0, 1, 0, 0, 8'd0,  0, 0, 0, 0, 8'd0, 4'd0));

    repeat (2) @(posedge clk);
    #1;
    check("reset_state", outs(), 16'h0000);
    rst = 1'b0;

    foreach (vecs[i]) begin
      step(vecs[i].st, vecs[i].sp, vecs[i].ak, vecs[i].tk, vecs[i].per);
      check($sformatf("vec%0d", i), outs(), vecs[i].exp);
    end

    // Reset held for 3 cycles mid-RUN overrides start and tick.
    step(1, 0, 0, 0, 8'd5);
    step(0, 0, 0, 1, 8'd0);
    check("pre_reset_run", outs(), {4'b1000, 8'd4, 4'd0});
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step(1, 0, 0, 1, 8'd7);
      check($sformatf("reset_mid_run%0d", c), outs(), 16'h0000);
    end
    rst = 1'b0;
    step(0, 0, 0, 0, 8'd0);
    check("post_reset_idle", outs(), 16'h0000);

    // Miss counting with ticks every 4 cycles, saturating at 15.
    step(1, 0, 0, 0, 8'd1);
    step(0, 0, 0, 1, 8'd0);
    check("miss_expire", outs(), {4'b0110, 8'd0, 4'd0});
    for (int c = 0; c < 80; c++) begin
      step(0, 0, 0, (c % 4) == 3, 8'd0);
      if (c == 7) check("miss_two", outs(), {4'b0100, 8'd0, 4'd2});
    end
    check("miss_saturated", outs(), {4'b0100, 8'd0, 4'd15});
    step(0, 0, 1, 0, 8'd0);
    check("miss_held_after_ack", outs(), {4'b0000, 8'd0, 4'd15});
    step(1, 0, 0, 0, 8'd5);
    check("miss_cleared_by_start", outs(), {4'b1000, 8'd5, 4'd0});
    step(0, 1, 0, 0, 8'd0);
    check("stop_after_miss", outs(), 16'h0000);

`ifdef TIMER_AUTO_RELOAD_EN
    begin
      logic [7:0] exp_rem;
      logic       exp_e;
      int         n_exp;
      auto_reload = 1'b1;
      step(1, 0, 0, 0, 8'd3);
      auto_reload = 1'b0;
      check("auto_start", outs(), {4'b1000, 8'd3, 4'd0});
      exp_rem = 8'd3;
      n_exp = 0;
      for (int c = 0; c < 48; c++) begin
        exp_e = 1'b0;
        if ((c % 4) == 3) begin
          if (exp_rem == 8'd1) begin
            exp_rem = 8'd3;
            exp_e = 1'b1;
            n_exp++;
          end else begin
            exp_rem = exp_rem - 8'd1;
          end
        end
        step(0, 0, 0, (c % 4) == 3, 8'd0);
        check($sformatf("auto_cyc%0d", c), outs(), {2'b10, exp_e, 1'b0, exp_rem, 4'd0});
      end
      check("auto_periods", 16'(n_exp), 16'd4);
      step(0, 1, 0, 0, 8'd0);
      check("auto_stop", outs(), 16'h0000);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
